// File: rtl/qrd_input_skewer.sv
// Ping-pong store for a serial 4x4 complex H; streams the skewed [H|I] rows and
// start flags into the QRD systolic core, advancing one step per in_ready.
module qrd_input_skewer #(
   parameter int IN_W    = 14,
   parameter int ONE_VAL = 1024,
   parameter int STEPS   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [IN_W-1:0] s_data_r,
   input  logic [IN_W-1:0] s_data_i,
   input  logic            s_last,
   input  logic            in_ready,
   output logic [IN_W-1:0] row_in_1_r,
   output logic [IN_W-1:0] row_in_1_i,
   output logic [IN_W-1:0] row_in_2_r,
   output logic [IN_W-1:0] row_in_2_i,
   output logic [IN_W-1:0] row_in_3_r,
   output logic [IN_W-1:0] row_in_3_i,
   output logic [IN_W-1:0] row_in_4_r,
   output logic [IN_W-1:0] row_in_4_i,
   output logic            row_in_1_f,
   output logic            row_in_2_f,
   output logic            row_in_3_f,
   output logic            frame_err,
   output logic            busy
);

   localparam int ONE_MAX = (1 << (IN_W - 1)) - 1;
   localparam logic [IN_W-1:0] ONE_SAT = (ONE_VAL > ONE_MAX) ? IN_W'(ONE_MAX) : IN_W'(ONE_VAL);
   localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

   logic [2*IN_W-1:0] mem_r [2][16];
   logic [1:0]        full_r, full_s;
   logic              wr_bank_r, wr_bank_s;
   logic              rd_bank_r, rd_bank_s;
   logic [3:0]        cnt_r, cnt_s;
   logic [4:0]        step_r, step_s;
   state_t            state_r, state_s;
   logic              accept_s, load_s, clear_s, load_bank_s;
   logic              ready_r, ready_s;
   logic              ferr_r, busy_r;
   logic [IN_W-1:0]   nxt_re_s [4];
   logic [IN_W-1:0]   nxt_im_s [4];
   logic [IN_W-1:0]   row_re_r [4];
   logic [IN_W-1:0]   row_im_r [4];
   logic [2:0]        flag_s, flag_r;

   // Bank bookkeeping for the fill side and the step sequencer for the stream side
   always_comb begin
      accept_s    = s_valid && ready_r;
      full_s      = full_r;
      wr_bank_s   = wr_bank_r;
      cnt_s       = cnt_r;
      state_s     = state_r;
      step_s      = step_r;
      rd_bank_s   = rd_bank_r;
      load_s      = 1'b0;
      clear_s     = 1'b0;
      load_bank_s = rd_bank_r;
      if (accept_s) begin
         if (cnt_r == 4'd15) begin
            full_s[wr_bank_r] = 1'b1;
            wr_bank_s         = ~wr_bank_r;
            cnt_s             = 4'd0;
         end else begin
            cnt_s = cnt_r + 4'd1;
         end
      end else begin
         cnt_s = cnt_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (full_r[rd_bank_r]) begin
               state_s = ST_STREAM;
               step_s  = 5'd0;
               load_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (in_ready) begin
               if (step_r == LAST_STEP) begin
                  full_s[rd_bank_r] = 1'b0;
                  rd_bank_s         = ~rd_bank_r;
                  step_s            = 5'd0;
                  // the other bank was already full: chain into it without a bubble
                  if (full_r[~rd_bank_r]) begin
                     load_s      = 1'b1;
                     load_bank_s = ~rd_bank_r;
                  end else begin
                     state_s = ST_IDLE;
                     clear_s = 1'b1;
                  end
               end else begin
                  step_s = step_r + 5'd1;
                  load_s = 1'b1;
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         default: begin
            state_s = ST_IDLE;
            clear_s = 1'b1;
         end
      endcase
      ready_s = ~full_s[wr_bank_s];
   end

   // Skewed [H|I] column selection for the step about to be driven
   always_comb begin
      int col;
      col = 0;
      for (int k = 0; k < 4; k++) begin
         col         = int'(step_s) - k;
         nxt_re_s[k] = '0;
         nxt_im_s[k] = '0;
         if (col >= 0 && col <= 3) begin
            {nxt_re_s[k], nxt_im_s[k]} = mem_r[load_bank_s][4'(4 * k + col)];
         end else if (col >= 4 && col <= 7) begin
            nxt_re_s[k] = (col - 4 == k) ? ONE_SAT : '0;
         end else begin
            nxt_re_s[k] = '0;
         end
      end
      flag_s = {step_s == 5'd4, step_s == 5'd2, step_s == 5'd0};
   end

   // Sample storage; validity is tracked by full_r so no reset is needed here
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_bank_r][cnt_r] <= {s_data_r, s_data_i};
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r    <= 2'b00;
         wr_bank_r <= 1'b0;
         rd_bank_r <= 1'b0;
         cnt_r     <= 4'd0;
         step_r    <= 5'd0;
         state_r   <= ST_IDLE;
         ready_r   <= 1'b1;
         ferr_r    <= 1'b0;
         busy_r    <= 1'b0;
         flag_r    <= 3'b000;
         for (int k = 0; k < 4; k++) begin
            row_re_r[k] <= '0;
            row_im_r[k] <= '0;
         end
      end else begin
         full_r    <= full_s;
         wr_bank_r <= wr_bank_s;
         rd_bank_r <= rd_bank_s;
         cnt_r     <= cnt_s;
         step_r    <= step_s;
         state_r   <= state_s;
         ready_r   <= ready_s;
         ferr_r    <= accept_s && (s_last ^ (cnt_r == 4'd15));
         busy_r    <= (state_s == ST_STREAM);
         if (load_s) begin
            flag_r <= flag_s;
            for (int k = 0; k < 4; k++) begin
               row_re_r[k] <= nxt_re_s[k];
               row_im_r[k] <= nxt_im_s[k];
            end
         end else if (clear_s) begin
            flag_r <= 3'b000;
            for (int k = 0; k < 4; k++) begin
               row_re_r[k] <= '0;
               row_im_r[k] <= '0;
            end
         end
      end
   end

   assign s_ready    = ready_r;
   assign frame_err  = ferr_r;
   assign busy       = busy_r;
   assign row_in_1_r = row_re_r[0];
   assign row_in_1_i = row_im_r[0];
   assign row_in_2_r = row_re_r[1];
   assign row_in_2_i = row_im_r[1];
   assign row_in_3_r = row_re_r[2];
   assign row_in_3_i = row_im_r[2];
   assign row_in_4_r = row_re_r[3];
   assign row_in_4_i = row_im_r[3];
   assign row_in_1_f = flag_r[0];
   assign row_in_2_f = flag_r[1];
   assign row_in_3_f = flag_r[2];

endmodule

// File: tb/tb_qrd_input_skewer.sv
// Bench for qrd_input_skewer: directed scenarios plus random traffic, checked against a
// matrix/step scoreboard built from the accepted samples.
module tb_qrd_input_skewer;

   localparam int IN_W = 14;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [IN_W-1:0] s_data_r = '0;
   logic [IN_W-1:0] s_data_i = '0;
   logic            s_last = 1'b0;
   logic            in_ready = 1'b0;
   logic [IN_W-1:0] r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i;
   logic            f1, f2, f3, frame_err, busy;

   always #5 clk = ~clk;

   qrd_input_skewer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last), .in_ready(in_ready),
      .row_in_1_r(r1r), .row_in_1_i(r1i), .row_in_2_r(r2r), .row_in_2_i(r2i),
      .row_in_3_r(r3r), .row_in_3_i(r3i), .row_in_4_r(r4r), .row_in_4_i(r4i),
      .row_in_1_f(f1), .row_in_2_f(f2), .row_in_3_f(f3),
      .frame_err(frame_err), .busy(busy)
   );

   int n_cmp = 0;
   int n_fail = 0;
   logic [IN_W-1:0] acc_r[$];
   logic [IN_W-1:0] acc_i[$];
   logic [IN_W-1:0] snd_r[$];
   logic [IN_W-1:0] snd_i[$];
   bit              snd_last[$];
   int  exp_mat = 0, exp_l = 0, in_idx = 0, cyc = 0;
   bit  mbusy = 1'b0, msr = 1'b1, busy_prev = 1'b0;
   int  valid_pct = 100, ir_mode = 1;
   int  fe_pulses = 0, n_acc = 0, busy_cycles = 0, busy_rises = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] obs_vec();
      return {13'd0, r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i, f3, f2, f1};
   endfunction

   // Row k at step l carries column l-k of [H|I]
   function automatic logic [127:0] exp_vec(input int m, input int l);
      logic [IN_W-1:0] er[4];
      logic [IN_W-1:0] ei[4];
      int c;
      for (int k = 0; k < 4; k++) begin
         c = l - k;
         er[k] = '0;
         ei[k] = '0;
         if (c >= 0 && c <= 3) begin
            er[k] = acc_r[16 * m + 4 * k + c];
            ei[k] = acc_i[16 * m + 4 * k + c];
         end else if (c - 4 == k) begin
            er[k] = 14'd1024;
         end
      end
      return {13'd0, er[0], ei[0], er[1], ei[1], er[2], ei[2], er[3], ei[3],
              1'(l == 4), 1'(l == 2), 1'(l == 0)};
   endfunction

   function automatic bit done();
      return (snd_r.size() == 0) && !mbusy && (acc_r.size() / 16 == exp_mat);
   endfunction

   task automatic push_matrix(input int kind);
      int v;
      for (int i = 0; i < 16; i++) begin
         if (kind == 0) begin
            v = 16 * (i / 4) + (i % 4) + 1;
            snd_r.push_back(14'(v));
            snd_i.push_back(14'(-v));
         end else begin
            snd_r.push_back(14'($urandom));
            snd_i.push_back(14'($urandom));
         end
         snd_last.push_back(kind == 2 ? (i == 9) : (i == 15));
      end
   endtask

   // One clock: predict the handshakes of the coming edge, then check the registered results
   task automatic cycle();
      int  f_pre;
      bit  nb, acc_s, fe_n;
      f_pre = acc_r.size() / 16 - exp_mat;
      acc_s = s_valid && msr;
      fe_n  = 1'b0;
      if (!mbusy) nb = (f_pre > 0);
      else if (in_ready && exp_l == 15) nb = (f_pre >= 2);
      else nb = 1'b1;
      if (mbusy && in_ready) begin
         check("data_avail", 128'(acc_r.size() >= 16 * (exp_mat + 1)), 128'(1));
         check($sformatf("step_m%0d_l%0d", exp_mat, exp_l), obs_vec(), exp_vec(exp_mat, exp_l));
         if (exp_l == 15) begin
            exp_l = 0;
            exp_mat++;
         end else begin
            exp_l++;
         end
      end else if (!mbusy) begin
         check("idle_zero", obs_vec(), 128'(0));
      end
      if (acc_s) begin
         fe_n = (s_last && in_idx != 15) || (!s_last && in_idx == 15);
         acc_r.push_back(s_data_r);
         acc_i.push_back(s_data_i);
         void'(snd_r.pop_front());
         void'(snd_i.pop_front());
         void'(snd_last.pop_front());
         in_idx = (in_idx + 1) % 16;
         n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mbusy = nb;
      msr   = (acc_r.size() / 16 - exp_mat) < 2;
      check("busy", 128'(busy), 128'(mbusy));
      check("s_ready", 128'(s_ready), 128'(msr));
      check("frame_err", 128'(frame_err), 128'(fe_n));
      if (frame_err) fe_pulses++;
      if (busy && !busy_prev) busy_rises++;
      if (busy) busy_cycles++;
      busy_prev = busy;
   endtask

   task automatic run_one();
      if (snd_r.size() > 0 && $urandom_range(99) < valid_pct) begin
         s_valid  = 1'b1;
         s_data_r = snd_r[0];
         s_data_i = snd_i[0];
         s_last   = snd_last[0];
      end else begin
         s_valid  = 1'b0;
         s_data_r = '0;
         s_data_i = '0;
         s_last   = 1'b0;
      end
      case (ir_mode)
         0: in_ready = 1'b0;
         1: in_ready = 1'b1;
         2: in_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: in_ready = ($urandom_range(99) < 60);
      endcase
      cycle();
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done()) break;
         run_one();
      end
      check("drain_done", 128'(done()), 128'(1));
   endtask

   task automatic reset_model();
      acc_r.delete(); acc_i.delete();
      snd_r.delete(); snd_i.delete(); snd_last.delete();
      exp_mat = 0; exp_l = 0; in_idx = 0;
      mbusy = 1'b0; msr = 1'b1; busy_prev = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_outputs", obs_vec(), 128'(0));
      check("rst_s_ready", 128'(s_ready), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_frame_err", 128'(frame_err), 128'(0));
      rst_n = 1'b1;

      // Single directed matrix, in_ready always high
      push_matrix(0);
      valid_pct = 100; ir_mode = 1;
      drain(200);

      // Same matrix with in_ready toggling 1,0,0,1
      push_matrix(0);
      ir_mode = 2;
      drain(300);

      // Back-to-back: no bubble between the two streams
      busy_cycles = 0; busy_rises = 0;
      push_matrix(1); push_matrix(1);
      ir_mode = 1;
      drain(300);
      check("b2b_busy_rises", 128'(busy_rises), 128'(1));
      check("b2b_busy_cycles", 128'(busy_cycles), 128'(32));

      // Framing: early s_last at sample 10, none at 16; then a clean matrix
      fe_pulses = 0;
      push_matrix(2); push_matrix(1);
      drain(300);
      check("frame_pulses", 128'(fe_pulses), 128'(2));

      // Backpressure: core stalled for 40 cycles with 3 matrices offered
      n_acc = 0;
      push_matrix(1); push_matrix(1); push_matrix(1);
      ir_mode = 0;
      repeat (40) run_one();
      check("bp_accepted", 128'(n_acc), 128'(32));
      check("bp_s_ready", 128'(s_ready), 128'(0));
      ir_mode = 1;
      drain(500);

      // Random traffic
      for (int i = 0; i < 6; i++) push_matrix(1);
      valid_pct = 70; ir_mode = 3;
      drain(3000);

      // Asynchronous reset mid-stream with the next matrix still filling
      push_matrix(1); push_matrix(1);
      valid_pct = 100; ir_mode = 1;
      repeat (25) run_one();
      s_valid = 1'b0; s_last = 1'b0; in_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", obs_vec(), 128'(0));
      check("mid_rst_s_ready", 128'(s_ready), 128'(1));
      check("mid_rst_busy", 128'(busy), 128'(0));
      reset_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean restart after reset
      push_matrix(0);
      valid_pct = 100; ir_mode = 1;
      drain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
